// File: rtl/pkg_imagem.sv
// Shared image-processing definitions: pixel width, default frame size, FSM states
// and elaboration-time width helpers used by the scaler blocks.
package pkg_imagem;

    localparam int unsigned PIXEL_W        = 8;
    localparam int unsigned LARGURA_PADRAO = 160;
    localparam int unsigned ALTURA_PADRAO  = 120;

    typedef enum logic [2:0] {
        OCIOSO,
        LER,
        ULTIMO,
        ESCREVE,
        CONCLUIDO
    } estado_t;

    function automatic int unsigned CLOG2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        return r;
    endfunction

    // Counter width that never collapses to zero bits (FATOR=1, single block row...)
    function automatic int unsigned largura_bits(input int unsigned n);
        return (CLOG2(n) > 0) ? CLOG2(n) : 1;
    endfunction

endpackage

// File: rtl/contador_bloco.sv
// Nested block counters: in-block offsets dj (fastest) and di, then block column bc
// and block row bl. Exposes next values so the top can register addresses in step.
module contador_bloco
    import pkg_imagem::*;
#(
    parameter int unsigned FATOR = 2,
    parameter int unsigned NBC   = 80,
    parameter int unsigned NBL   = 60,
    parameter int unsigned OFF_W = largura_bits(FATOR),
    parameter int unsigned BC_W  = largura_bits(NBC),
    parameter int unsigned BL_W  = largura_bits(NBL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             avanca_off,
    input  logic             avanca_blk,
    output logic [OFF_W-1:0] dj,
    output logic [OFF_W-1:0] di,
    output logic [BC_W-1:0]  bc,
    output logic [BL_W-1:0]  bl,
    output logic [OFF_W-1:0] dj_prox_c,
    output logic [OFF_W-1:0] di_prox_c,
    output logic [BC_W-1:0]  bc_prox_c,
    output logic [BL_W-1:0]  bl_prox_c,
    output logic             fim_bloco_c,
    output logic             fim_quadro_c
);

    logic dj_fim, di_fim, bc_fim, bl_fim;

    assign dj_fim       = (dj == OFF_W'(FATOR - 1));
    assign di_fim       = (di == OFF_W'(FATOR - 1));
    assign bc_fim       = (bc == BC_W'(NBC - 1));
    assign bl_fim       = (bl == BL_W'(NBL - 1));
    assign fim_bloco_c  = dj_fim && di_fim;
    assign fim_quadro_c = bc_fim && bl_fim;

    always_comb begin
        dj_prox_c = dj;
        di_prox_c = di;
        bc_prox_c = bc;
        bl_prox_c = bl;
        if (clr) begin
            dj_prox_c = '0;
            di_prox_c = '0;
            bc_prox_c = '0;
            bl_prox_c = '0;
        end else begin
            if (avanca_off) begin
                if (dj_fim) begin
                    dj_prox_c = '0;
                    di_prox_c = di_fim ? '0 : di + OFF_W'(1);
                end else begin
                    dj_prox_c = dj + OFF_W'(1);
                end
            end
            if (avanca_blk) begin
                bc_prox_c = bc_fim ? '0 : bc + BC_W'(1);
                if (bc_fim) bl_prox_c = bl_fim ? '0 : bl + BL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dj <= '0;
            di <= '0;
            bc <= '0;
            bl <= '0;
        end else begin
            dj <= dj_prox_c;
            di <= di_prox_c;
            bc <= bc_prox_c;
            bl <= bl_prox_c;
        end
    end

endmodule

// File: rtl/media_blocos.sv
// Block-average downscaler: reads the source image from a 1-cycle-latency ROM and
// writes the mean of each FATOR x FATOR block to the VGA frame RAM.
module media_blocos
    import pkg_imagem::*;
#(
    parameter int unsigned FATOR   = 2,
    parameter int unsigned LARGURA = LARGURA_PADRAO,
    parameter int unsigned ALTURA  = ALTURA_PADRAO,
    parameter int unsigned ROM_AW  = 15,
    parameter int unsigned RAM_AW  = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        pixel_rom,
    output logic [ROM_AW-1:0] addr_rom,
    output logic [7:0]        pixel_saida,
    output logic [RAM_AW-1:0] addr_ram_vga,
    output logic              we_ram,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BLOCOS_L = LARGURA / FATOR;
    localparam int unsigned BLOCOS_A = ALTURA / FATOR;
    localparam int unsigned DESLOC   = 2 * CLOG2(FATOR);
    localparam int unsigned ACC_W    = PIXEL_W + DESLOC;
    localparam int unsigned OFF_W    = largura_bits(FATOR);
    localparam int unsigned BC_W     = largura_bits(BLOCOS_L);
    localparam int unsigned BL_W     = largura_bits(BLOCOS_A);

    estado_t          estado;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] soma_c;
    logic             clr_c, av_off_c, av_blk_c, primeiro_c;
    logic [31:0]      end_rom_c, end_ram_c;

    logic [OFF_W-1:0] dj, di, dj_p, di_p;
    logic [BC_W-1:0]  bc, bc_p;
    logic [BL_W-1:0]  bl, bl_p;
    logic             fim_bloco_c, fim_quadro_c;

    contador_bloco #(
        .FATOR (FATOR),
        .NBC   (BLOCOS_L),
        .NBL   (BLOCOS_A),
        .OFF_W (OFF_W),
        .BC_W  (BC_W),
        .BL_W  (BL_W)
    ) u_contador (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr_c),
        .avanca_off   (av_off_c),
        .avanca_blk   (av_blk_c),
        .dj           (dj),
        .di           (di),
        .bc           (bc),
        .bl           (bl),
        .dj_prox_c    (dj_p),
        .di_prox_c    (di_p),
        .bc_prox_c    (bc_p),
        .bl_prox_c    (bl_p),
        .fim_bloco_c  (fim_bloco_c),
        .fim_quadro_c (fim_quadro_c)
    );

    // ROM address tracks the counters' next values so it is registered yet in step
    always_comb begin
        clr_c      = (estado == OCIOSO) && start;
        av_off_c   = (estado == LER);
        av_blk_c   = (estado == ESCREVE);
        primeiro_c = (dj == '0) && (di == '0);
        soma_c     = acc + ACC_W'(pixel_rom);
        end_rom_c  = (32'(bl_p) * FATOR + 32'(di_p)) * LARGURA + 32'(bc_p) * FATOR + 32'(dj_p);
        end_ram_c  = 32'(bl) * BLOCOS_L + 32'(bc);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado       <= OCIOSO;
            acc          <= '0;
            addr_rom     <= '0;
            pixel_saida  <= '0;
            addr_ram_vga <= '0;
            we_ram       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            we_ram   <= 1'b0;
            done     <= 1'b0;
            addr_rom <= ROM_AW'(end_rom_c);
            case (estado)
                OCIOSO: begin
                    if (start) begin
                        acc    <= '0;
                        busy   <= 1'b1;
                        estado <= LER;
                    end
                end
                LER: begin
                    // First LER cycle has no ROM data yet
                    if (!primeiro_c) acc <= soma_c;
                    if (fim_bloco_c) estado <= ULTIMO;
                end
                ULTIMO: begin
                    acc          <= soma_c;
                    pixel_saida  <= PIXEL_W'(soma_c >> DESLOC);
                    addr_ram_vga <= RAM_AW'(end_ram_c);
                    we_ram       <= 1'b1;
                    estado       <= ESCREVE;
                end
                ESCREVE: begin
                    acc <= '0;
                    if (fim_quadro_c) begin
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        estado <= CONCLUIDO;
                    end else begin
                        estado <= LER;
                    end
                end
                CONCLUIDO: estado <= OCIOSO;
                default:   estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: doc/media_blocos.md
# media_blocos

Block-average downscaler, the inverse of the pixel-replication upscaler. It reads a LARGURA×ALTURA 8-bit grayscale image from a synchronous ROM and averages each non-overlapping FATOR×FATOR block. Each average is written as one pixel of a (LARGURA/FATOR)×(ALTURA/FATOR) image into the VGA frame RAM. It sits between the image ROM and the VGA RAM write port and is triggered by the control FSM through `start`/`done`.

## Interface
- FATOR, 2, block edge; legal values 1, 2, 4
- LARGURA, 160, source width in pixels; must be a multiple of FATOR
- ALTURA, 120, source height in pixels; must be a multiple of FATOR
- ROM_AW, 15, ROM address width; must satisfy 2^ROM_AW ≥ LARGURA·ALTURA
- RAM_AW, 13, RAM address width; must satisfy 2^RAM_AW ≥ (LARGURA/FATOR)·(ALTURA/FATOR)

- clk  in  1  single clock; all logic is on its rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to process one frame; ignored while `busy`
- pixel_rom  in  8  ROM data, valid one cycle after `addr_rom`
- addr_rom  out  ROM_AW  ROM read address
- pixel_saida  out  8  averaged pixel
- addr_ram_vga  out  RAM_AW  destination RAM address
- we_ram  out  1  RAM write strobe; high exactly one cycle per output pixel
- busy  out  1  high from the cycle after `start` is accepted until `done`
- done  out  1  one-cycle pulse after the last write

## Operation
- States are OCIOSO, LER, ULTIMO, ESCREVE and CONCLUIDO.
- **Counters:**
  - `bc` is the block column, range 0..LARGURA/FATOR-1.
  - `bl` is the block row, range 0..ALTURA/FATOR-1.
  - `dj` and `di` are the in-block offsets, range 0..FATOR-1; `dj` is the fastest.
- **OCIOSO:** on `start`=1, clear the counters and accumulator, then go to LER.
- **LER:**
  - `addr_rom` = (bl·FATOR+di)·LARGURA + (bc·FATOR+dj).
  - `dj` increments each cycle; `di` increments when `dj` wraps.
  - From the second LER cycle on, the accumulator adds `pixel_rom`.
  - When di=dj=FATOR-1, go to ULTIMO.
- **ULTIMO:** accumulate the final sample, then go to ESCREVE.
- **ESCREVE:**
  - `we_ram`=1.
  - `pixel_saida` = acc >> (2·log2 FATOR), truncating.
  - `addr_ram_vga` = bl·(LARGURA/FATOR) + bc.
  - Clear the accumulator and advance `bc`; when `bc` wraps, advance `bl`.
  - After the last block go to CONCLUIDO; otherwise go to LER.
- **CONCLUIDO:** `done`=1 for one cycle, then go to OCIOSO.
- Accumulator width is 8 + 2·log2(FATOR). It cannot overflow: for FATOR=4, 16·255 = 4080 fits in 12 bits.
- FATOR=1 makes the block a straight copy of the image, 3 cycles per pixel.
- No combinational path exists from `pixel_rom` or `start` to any output. All outputs decode from registers only.

## Timing
- ROM read latency is fixed at 1 cycle.
- One block takes FATOR²+2 cycles. The full frame takes (FATOR²+2)·(LARGURA/FATOR)·(ALTURA/FATOR) cycles from the `start` edge to the `done` cycle, plus 1 cycle for CONCLUIDO.
- The first `we_ram` occurs FATOR²+1 cycles after the accepting edge.
- `start` during `busy`: ignored. `start` held high: a new frame starts only on the first cycle back in OCIOSO.
- **Reset values (any cycle, including mid-frame):**
  - State = OCIOSO.
  - All counters and the accumulator = 0.
  - `addr_rom`, `addr_ram_vga` and `pixel_saida` = 0.
  - `we_ram`, `busy` and `done` = 0.
- Reset mid-frame: no further writes. Partial RAM contents are left as they are.
- Outside ESCREVE, `pixel_saida` and `addr_ram_vga` hold their last written values.

## Structure
- Shared package `pkg_imagem`:
  - state enum
  - `CLOG2` function
  - pixel width constant (8)
  - default LARGURA/ALTURA constants, shared with the replication upscaler
- Sub-module `contador_bloco` holds the `dj`/`di`/`bc`/`bl` counters and produces wrap flags and the last-block flag.
- The top-level holds the FSM, the accumulator and the address arithmetic.

## Test plan
- **Reset:** assert `rst`=0 mid-LER → all outputs 0 the same cycle. Release, pulse `start` → first `addr_rom`=0.
- **Constant image:** LARGURA=8, ALTURA=4, FATOR=2, every pixel 0x80 → 8 writes, `addr_ram_vga` 0..7, all data 0x80. `done` 48 cycles after the `start` edge.
- **Averaging and truncation:**
  - Block {10,20,30,40} → 25.
  - Block {255,255,255,255} → 255.
  - Block {1,1,1,2} → 1.
- **Address order:** LARGURA=8, FATOR=2:
  - first block → `addr_rom` 0, 1, 8, 9;
  - second block → 2, 3, 10, 11;
  - last block writes `addr_ram_vga`=7.
- **Reset mid-frame:** assert `rst` after the 3rd write → `we_ram` drops immediately with no 4th write. A new `start` rewrites from `addr_ram_vga`=0.
- **FATOR=4 and start handling:** 8×8 ramp image → 4 writes, 18 cycles per block, sums correct and shifted right by 4. A `start` pulse during `busy` has no effect.
